// File: rtl/wb_master_single.sv
// Wishbone B4 classic single-cycle master: turns one valid/ready command into one
// bus READ or WRITE, then returns one response (read data or timeout error).
module wb_master_single #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int GRANULE    = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           cmd_valid_i,
  output logic                           cmd_ready_o,
  input  logic                           cmd_we_i,
  input  logic [ADDR_WIDTH-1:0]          cmd_adr_i,
  input  logic [DATA_WIDTH-1:0]          cmd_dat_i,
  input  logic [DATA_WIDTH/GRANULE-1:0]  cmd_sel_i,
  output logic                           rsp_valid_o,
  input  logic                           rsp_ready_i,
  output logic [DATA_WIDTH-1:0]          rsp_dat_o,
  output logic                           rsp_err_o,
  output logic                           cyc_o,
  output logic                           stb_o,
  output logic                           we_o,
  output logic [ADDR_WIDTH-1:0]          adr_o,
  output logic [DATA_WIDTH-1:0]          dat_o,
  output logic [DATA_WIDTH/GRANULE-1:0]  sel_o,
  input  logic [DATA_WIDTH-1:0]          dat_i,
  input  logic                           ack_i
);

  localparam int SEL_WIDTH = DATA_WIDTH / GRANULE;
  localparam int CNT_WIDTH = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = (TIMEOUT > 0) ? CNT_WIDTH'(TIMEOUT - 1) : '0;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESPOND
  } state_e;

  state_e                  state_q;
  logic [CNT_WIDTH-1:0]    cnt_q;
  logic [CNT_WIDTH-1:0]    cnt_d;
  logic                    timeout_d;
  logic                    cmd_ready_q;
  logic                    rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rsp_dat_q;
  logic                    rsp_err_q;
  logic                    cyc_q;
  logic                    stb_q;
  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   adr_q;
  logic [DATA_WIDTH-1:0]   dat_q;
  logic [SEL_WIDTH-1:0]    sel_q;

  // Counter saturates so a disabled timeout can never wrap back onto the limit.
  assign cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  assign timeout_d = (TIMEOUT != 0) && (cnt_q == CNT_LIMIT);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cmd_ready_q && cmd_valid_i) begin
            cmd_ready_q <= 1'b0;
            cyc_q       <= 1'b1;
            stb_q       <= 1'b1;
            we_q        <= cmd_we_i;
            adr_q       <= cmd_adr_i;
            dat_q       <= cmd_dat_i;
            sel_q       <= cmd_sel_i;
            cnt_q       <= '0;
            state_q     <= BUS;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        BUS: begin
          // ack has priority over a timeout landing on the same edge.
          if (ack_i || timeout_d) begin
            rsp_dat_q   <= (ack_i && !we_q) ? dat_i : '0;
            rsp_err_q   <= !ack_i;
            rsp_valid_q <= 1'b1;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            state_q     <= RESPOND;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        RESPOND: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;
  assign cyc_o       = cyc_q;
  assign stb_o       = stb_q;
  assign we_o        = we_q;
  assign adr_o       = adr_q;
  assign dat_o       = dat_q;
  assign sel_o       = sel_q;

endmodule

// File: tb/tb_wb_master_single.sv
// Bench for wb_master_single: register slave, transaction-timeline reference model,
// per-cycle output compare plus directed literal checks and randomized commands.
module tb_wb_master_single;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic          cmd_we_i;
  logic [AW-1:0] cmd_adr_i;
  logic [DW-1:0] cmd_dat_i;
  logic [SW-1:0] cmd_sel_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [DW-1:0] rsp_dat_o;
  logic          rsp_err_o;
  logic          cyc_o;
  logic          stb_o;
  logic          we_o;
  logic [AW-1:0] adr_o;
  logic [DW-1:0] dat_o;
  logic [SW-1:0] sel_o;
  logic [DW-1:0] dat_i;
  logic          ack_i;

  always #5 clk_i = ~clk_i;

  wb_master_single #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .GRANULE(8),
    .TIMEOUT(TO)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i),
    .cmd_dat_i(cmd_dat_i),
    .cmd_sel_i(cmd_sel_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_dat_o(rsp_dat_o),
    .rsp_err_o(rsp_err_o),
    .cyc_o(cyc_o),
    .stb_o(stb_o),
    .we_o(we_o),
    .adr_o(adr_o),
    .dat_o(dat_o),
    .sel_o(sel_o),
    .dat_i(dat_i),
    .ack_i(ack_i)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Register slave: acks on the ackLat-th strobe cycle, random ack/data while idle.
  logic [DW-1:0] slaveMem [16];
  int ackLat = 3;
  int stbSeen = 0;

  always @(negedge clk_i) begin
    if (stb_o === 1'b1) begin
      stbSeen = stbSeen + 1;
      if (stbSeen == ackLat) begin
        ack_i = 1'b1;
        dat_i = slaveMem[adr_o[5:2]];
        if (we_o)
          for (int b = 0; b < SW; b++)
            if (sel_o[b]) slaveMem[adr_o[5:2]][8*b +: 8] = dat_o[8*b +: 8];
      end else begin
        ack_i = 1'b0;
        dat_i = $urandom;
      end
    end else begin
      stbSeen = 0;
      ack_i = 1'($urandom_range(0, 1));
      dat_i = $urandom;
    end
  end

  // Reference model: each accepted command strobes for a known duration, then responds.
  logic          started = 1'b0;
  logic          mReady = 1'b0;
  logic          mInFlight = 1'b0;
  logic          mRspValid = 1'b0;
  logic          mRspErr = 1'b0;
  logic [DW-1:0] mRspDat = '0;
  int            mStbLeft = 0;
  int            mAccepts = 0;
  int            mRsps = 0;
  logic          mWillErr = 1'b0;
  logic          mWe = 1'b0;
  logic [AW-1:0] mAdr = '0;
  logic [DW-1:0] mDat = '0;
  logic [SW-1:0] mSel = '0;
  logic [DW-1:0] modelMem [16];

  always @(posedge clk_i) begin
    started = 1'b1;
    if (rst_i) begin
      mReady = 1'b0;
      mInFlight = 1'b0;
      mStbLeft = 0;
      mRspValid = 1'b0;
      mRspErr = 1'b0;
    end else if (mRspValid) begin
      if (rsp_ready_i) begin
        mRspValid = 1'b0;
        mRspErr = 1'b0;
        mInFlight = 1'b0;
        mReady = 1'b1;
        mRsps++;
      end
    end else if (mStbLeft > 0) begin
      mStbLeft--;
      if (mStbLeft == 0) begin
        mRspValid = 1'b1;
        mRspErr = mWillErr;
        mRspDat = '0;
        if (!mWillErr && mWe) begin
          for (int b = 0; b < SW; b++)
            if (mSel[b]) modelMem[mAdr[5:2]][8*b +: 8] = mDat[8*b +: 8];
        end else if (!mWillErr) begin
          mRspDat = modelMem[mAdr[5:2]];
        end
      end
    end else if (mReady && cmd_valid_i) begin
      mReady = 1'b0;
      mInFlight = 1'b1;
      mAccepts++;
      mWe = cmd_we_i;
      mAdr = cmd_adr_i;
      mDat = cmd_dat_i;
      mSel = cmd_sel_i;
      mWillErr = (TO != 0) && (ackLat > TO);
      mStbLeft = mWillErr ? TO : ackLat;
    end else begin
      mReady = 1'b1;
    end
  end

  always @(negedge clk_i) begin
    if (started) begin
      checkOutput("cmd_ready", cmd_ready_o, mReady);
      checkOutput("stb", stb_o, mStbLeft > 0);
      checkOutput("cyc", cyc_o, mStbLeft > 0);
      if (mStbLeft > 0) begin
        checkOutput("we", we_o, mWe);
        checkOutput("adr", adr_o, mAdr);
        checkOutput("dat", dat_o, mDat);
        checkOutput("sel", sel_o, mSel);
      end else begin
        checkOutput("we_idle", we_o, 1'b0);
        checkOutput("adr_idle", adr_o, '0);
        checkOutput("dat_idle", dat_o, '0);
        checkOutput("sel_idle", sel_o, '0);
      end
      checkOutput("rsp_valid", rsp_valid_o, mRspValid);
      checkOutput("rsp_err", rsp_err_o, mRspErr);
      if (mRspValid) checkOutput("rsp_dat", rsp_dat_o, mRspDat);
    end
  end

  task automatic randomizeCmd();
    cmd_we_i  = 1'($urandom_range(0, 1));
    cmd_adr_i = AW'($urandom);
    cmd_dat_i = $urandom;
    cmd_sel_i = SW'($urandom);
  endtask

  task automatic applyStimulus(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                               input logic [SW-1:0] sel, input int lat, input bit holdValid,
                               input int holdReady, output logic [DW-1:0] rDat, output logic rErr,
                               output int stbCnt, output int validCnt);
    int startAcc;
    int startRsp;
    int budget;
    rDat = '0;
    rErr = 1'b0;
    stbCnt = 0;
    validCnt = 0;
    ackLat = lat;
    cmd_we_i = we;
    cmd_adr_i = adr;
    cmd_dat_i = dat;
    cmd_sel_i = sel;
    cmd_valid_i = 1'b1;
    startAcc = mAccepts;
    startRsp = mRsps;
    budget = 0;
    while (mAccepts == startAcc && budget < 50) begin
      @(negedge clk_i);
      budget++;
    end
    if (mAccepts == startAcc) begin
      checkOutput("accept_wait", 64'(budget), 64'(0));
      cmd_valid_i = 1'b0;
      return;
    end
    cmd_valid_i = holdValid;
    if (holdValid) randomizeCmd();
    budget = 0;
    forever begin
      if (stb_o) stbCnt++;
      if (rsp_valid_o) begin
        validCnt++;
        rDat = rsp_dat_o;
        rErr = rsp_err_o;
      end
      rsp_ready_i = (holdReady > 0) ? (validCnt > holdReady) : 1'($urandom_range(0, 1));
      @(negedge clk_i);
      budget++;
      if (mRsps != startRsp) break;
      if (budget >= 100) begin
        checkOutput("rsp_wait", 64'(budget), 64'(0));
        break;
      end
      if (holdValid) randomizeCmd();
    end
    cmd_valid_i = 1'b0;
    rsp_ready_i = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] rDat;
    logic          rErr;
    int            stbCnt;
    int            validCnt;
    int            startRsp;

    for (int i = 0; i < 16; i++) begin
      slaveMem[i] = '0;
      modelMem[i] = '0;
    end
    rst_i = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_we_i = 1'b0;
    cmd_adr_i = '0;
    cmd_dat_i = '0;
    cmd_sel_i = '0;
    rsp_ready_i = 1'b0;
    dat_i = '0;
    ack_i = 1'b0;

    repeat (3) @(negedge clk_i);
    checkOutput("reset_cmd_ready", cmd_ready_o, 1'b0);
    checkOutput("reset_stb", stb_o, 1'b0);
    checkOutput("reset_rsp_valid", rsp_valid_o, 1'b0);
    rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("post_reset_ready", cmd_ready_o, 1'b1);

    applyStimulus(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 3, 1'b0, 0, rDat, rErr, stbCnt, validCnt);
    checkOutput("wr_err", rErr, 1'b0);
    checkOutput("wr_dat", rDat, 32'h0);
    checkOutput("wr_stb_len", 64'(stbCnt), 64'(3));

    applyStimulus(1'b0, 16'h0010, 32'h0, 4'hF, 3, 1'b0, 0, rDat, rErr, stbCnt, validCnt);
    checkOutput("rd_dat", rDat, 32'hDEADBEEF);
    checkOutput("rd_err", rErr, 1'b0);
    checkOutput("rd_stb_len", 64'(stbCnt), 64'(3));

    applyStimulus(1'b1, 16'h0020, 32'hAABBCCDD, 4'h3, 3, 1'b0, 0, rDat, rErr, stbCnt, validCnt);
    applyStimulus(1'b0, 16'h0020, 32'h0, 4'hF, 3, 1'b0, 0, rDat, rErr, stbCnt, validCnt);
    checkOutput("partial_sel_dat", rDat, 32'h0000CCDD);

    applyStimulus(1'b0, 16'h0010, 32'h0, 4'hF, 100, 1'b0, 0, rDat, rErr, stbCnt, validCnt);
    checkOutput("timeout_stb_len", 64'(stbCnt), 64'(4));
    checkOutput("timeout_err", rErr, 1'b1);
    checkOutput("timeout_dat", rDat, 32'h0);

    applyStimulus(1'b0, 16'h0010, 32'h0, 4'hF, 2, 1'b1, 10, rDat, rErr, stbCnt, validCnt);
    checkOutput("bp_valid_cycles", 64'(validCnt), 64'(11));
    checkOutput("bp_dat", rDat, 32'hDEADBEEF);
    checkOutput("bp_stb_len", 64'(stbCnt), 64'(2));

    // Abort a command mid-bus with a one-cycle reset; it must never respond.
    startRsp = mRsps;
    ackLat = 100;
    cmd_we_i = 1'b1;
    cmd_adr_i = 16'h0010;
    cmd_dat_i = 32'h0BAD0BAD;
    cmd_sel_i = 4'hF;
    cmd_valid_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    checkOutput("pre_reset_stb", stb_o, 1'b1);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    checkOutput("mid_reset_stb", stb_o, 1'b0);
    checkOutput("mid_reset_cyc", cyc_o, 1'b0);
    checkOutput("mid_reset_rsp_valid", rsp_valid_o, 1'b0);
    @(negedge clk_i);
    checkOutput("mid_reset_ready", cmd_ready_o, 1'b1);
    rsp_ready_i = 1'b1;
    repeat (8) @(negedge clk_i);
    rsp_ready_i = 1'b0;
    checkOutput("aborted_no_rsp", 64'(mRsps - startRsp), 64'(0));

    applyStimulus(1'b0, 16'h0010, 32'h0, 4'hF, 4, 1'b0, 0, rDat, rErr, stbCnt, validCnt);
    checkOutput("late_ack_err", rErr, 1'b0);
    checkOutput("late_ack_dat", rDat, 32'hDEADBEEF);
    checkOutput("late_ack_stb_len", 64'(stbCnt), 64'(4));

    applyStimulus(1'b1, 16'h0010, 32'h12345678, 4'h0, 2, 1'b0, 0, rDat, rErr, stbCnt, validCnt);
    checkOutput("sel0_stb_len", 64'(stbCnt), 64'(2));
    applyStimulus(1'b0, 16'h0010, 32'h0, 4'hF, 1, 1'b0, 0, rDat, rErr, stbCnt, validCnt);
    checkOutput("sel0_unchanged", rDat, 32'hDEADBEEF);
    checkOutput("ack1_stb_len", 64'(stbCnt), 64'(1));

    for (int n = 0; n < 150; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), AW'($urandom), $urandom, SW'($urandom),
                    $urandom_range(1, 6), 1'($urandom_range(0, 1)), 0,
                    rDat, rErr, stbCnt, validCnt);
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
